alarm_tone_scheduler: RTL



---
 rtl/alarm_tone_pkg.sv | 47 ++++
 rtl/tone_half_period_gen.sv | 51 +++++
 rtl/alarm_tone_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alarm_tone_pkg.sv
// Shared types, tone table and small helpers for the alarm tone scheduler.
// The table is sized for exactly four requesters.
package alarm_tone_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY_A = 2'd1,
    PLAY_B = 2'd2,
    GAP    = 2'd3
  } state_e;

  localparam int REQ_COUNT = 4;

  localparam int unsigned BASE_HP_A [REQ_COUNT] = '{3, 4, 6, 2};
  localparam int unsigned BASE_HP_B [REQ_COUNT] = '{5, 7, 6, 9};

  // Half-period in clk cycles for an owner/phase; caller truncates to its counter width.
  function automatic int unsigned half_period(input logic [1:0]  idx,
                                              input logic        phase_b,
                                              input int unsigned scale);
    int unsigned base;
    base = phase_b ? BASE_HP_B[idx] : BASE_HP_A[idx];
    return base * scale;
  endfunction

  function automatic logic [REQ_COUNT-1:0] lowest_set(input logic [REQ_COUNT-1:0] v);
    logic [REQ_COUNT-1:0] r;
    r = '0;
    for (int i = REQ_COUNT - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [REQ_COUNT-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = REQ_COUNT - 1; i >= 0; i--) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tone_half_period_gen.sv
// Half-period down-counter driving a square-wave speaker flop.
// load_i reloads the counter without touching the speaker unless clear_i is also set.
module tone_half_period_gen #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [HP_W-1:0] half_period_i,
  output logic            speaker_o
);

  localparam logic [HP_W-1:0] HP_ONE = HP_W'(1);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            spk_q, spk_d;

  always_comb begin
    cnt_d = cnt_q;
    spk_d = spk_q;
    if (load_i) begin
      cnt_d = half_period_i - HP_ONE;
      if (clear_i) spk_d = 1'b0;
    end else if (clear_i) begin
      cnt_d = '0;
      spk_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        spk_d = ~spk_q;
        cnt_d = half_period_i - HP_ONE;
      end else begin
        cnt_d = cnt_q - HP_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end

  assign speaker_o = spk_q;

endmodule

// File: rtl/alarm_tone_scheduler.sv
// Fixed-priority arbiter sharing one speaker between four two-tone sirens, with a gap between owners.
// Define ALARM_TONE_PREEMPT_EN to let a higher-priority request take over mid-play without a gap.
module alarm_tone_scheduler
  import alarm_tone_pkg::*;
#(
  parameter int NUM_REQ      = REQ_COUNT,
  parameter int DWELL_CYCLES = 13500000,
  parameter int GAP_CYCLES   = 2700000,
  parameter int TONE_SCALE   = 100,
  parameter int HP_W         = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               tone_b,
  output logic               speaker
);

  localparam int DW_W = ($clog2(DWELL_CYCLES) < 1) ? 1 : $clog2(DWELL_CYCLES);
  localparam int GP_W = ($clog2(GAP_CYCLES) < 1) ? 1 : $clog2(GAP_CYCLES);

  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
  localparam logic [GP_W-1:0] GAP_LOAD   = GP_W'(GAP_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_ONE     = DW_W'(1);
  localparam logic [GP_W-1:0] GP_ONE     = GP_W'(1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               tone_b_q, tone_b_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [GP_W-1:0]    gap_q, gap_d;

  logic [NUM_REQ-1:0] winner;
  logic               tone_load, tone_clear, tone_en;
  logic [1:0]         hp_owner;
  logic               hp_phase;
  logic [HP_W-1:0]    hp_sel;

  assign winner = lowest_set(req);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    tone_b_d   = tone_b_q;
    dwell_d    = dwell_q;
    gap_d      = gap_q;
    tone_load  = 1'b0;
    tone_clear = 1'b0;
    tone_en    = 1'b0;
    hp_owner   = onehot_idx(grant_q);
    hp_phase   = tone_b_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d    = winner;
          tone_b_d   = 1'b0;
          dwell_d    = DWELL_LOAD;
          tone_load  = 1'b1;
          tone_clear = 1'b1;
          hp_owner   = onehot_idx(winner);
          hp_phase   = 1'b0;
          state_d    = PLAY_A;
        end
      end

      PLAY_A, PLAY_B: begin
        tone_en = 1'b1;
        if (dwell_q == '0) begin
          // Release is only honoured at a phase boundary so phases always complete.
          if ((req & grant_q) != '0) begin
            state_d   = (state_q == PLAY_A) ? PLAY_B : PLAY_A;
            tone_b_d  = ~tone_b_q;
            dwell_d   = DWELL_LOAD;
            tone_load = 1'b1;
            hp_phase  = ~tone_b_q;
          end else begin
            state_d    = GAP;
            grant_d    = '0;
            tone_b_d   = 1'b0;
            gap_d      = GAP_LOAD;
            tone_clear = 1'b1;
          end
        end else begin
          dwell_d = dwell_q - DW_ONE;
        end
`ifdef ALARM_TONE_PREEMPT_EN
        if ((req & (grant_q - NUM_REQ'(1))) != '0) begin
          state_d    = PLAY_A;
          grant_d    = winner;
          tone_b_d   = 1'b0;
          dwell_d    = DWELL_LOAD;
          tone_load  = 1'b1;
          tone_clear = 1'b1;
          hp_owner   = onehot_idx(winner);
          hp_phase   = 1'b0;
        end
`endif
      end

      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GP_ONE;
      end

      default: state_d = IDLE;
    endcase

    hp_sel = HP_W'(half_period(hp_owner, hp_phase, TONE_SCALE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      tone_b_q <= 1'b0;
      dwell_q  <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      tone_b_q <= tone_b_d;
      dwell_q  <= dwell_d;
      gap_q    <= gap_d;
    end
  end

  tone_half_period_gen #(
    .HP_W(HP_W)
  ) u_tone (
    .clk          (clk),
    .reset_n      (reset_n),
    .load_i       (tone_load),
    .clear_i      (tone_clear),
    .en_i         (tone_en),
    .half_period_i(hp_sel),
    .speaker_o    (speaker)
  );

  assign grant  = grant_q;
  assign busy   = (state_q != IDLE);
  assign tone_b = tone_b_q;

endmodule
